// File: rtl/calc_cmd_driver.sv
// Command-side driver for the calc accumulator: turns a requested 8-bit target into
// the shortest comA/comB sequence and tracks calc's value in a local shadow register.
module calc_cmd_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] target,
  output logic       comA,
  output logic       comB,
  output logic       busy,
  output logic       done,
  output logic [7:0] shadow
);

  typedef enum logic [1:0] {IDLE, CLEAR, STEP, DONE} stateT;

  stateT      state;
  logic [7:0] tgt;
  logic       dirInc;

  logic [7:0] up;
  logic [7:0] down;
  logic [7:0] best;
  logic [8:0] clr;
  logic       upWins;
  logic [7:0] stepNext;

  // Path costs are evaluated against the live target so the choice is made on the accept edge.
  always_comb begin
    up       = target - shadow;
    down     = shadow - target;
    upWins   = (up <= down);
    best     = upWins ? up : down;
    clr      = {1'b0, target} + 9'd1;
    stepNext = dirInc ? shadow + 8'd1 : shadow - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tgt    <= 8'd0;
      dirInc <= 1'b1;
      shadow <= 8'd0;
      comA   <= 1'b0;
      comB   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          comA <= 1'b0;
          comB <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            tgt  <= target;
            busy <= 1'b1;
            if (target == shadow) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (clr < {1'b0, best}) begin
              state <= CLEAR;
              comA  <= 1'b1;
              comB  <= 1'b1;
            end else begin
              state  <= STEP;
              dirInc <= upWins;
              comA   <= upWins;
              comB   <= ~upWins;
            end
          end
        end
        CLEAR: begin
          shadow <= 8'd0;
          if (tgt == 8'd0) begin
            state <= DONE;
            comA  <= 1'b0;
            comB  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= STEP;
            dirInc <= 1'b1;
            comA   <= 1'b1;
            comB   <= 1'b0;
          end
        end
        STEP: begin
          // Stop on the edge whose command lands calc exactly on the target.
          shadow <= stepNext;
          if (stepNext == tgt) begin
            state <= DONE;
            comA  <= 1'b0;
            comB  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Self-checking bench for calc_cmd_driver: directed vector table, corner sequences and
// random targets checked against a cost-based command-sequence model.
module tb_calc_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] target;
  logic       comA, comB, busy, done;
  logic [7:0] shadow;

  int nChecks = 0;
  int nPassed = 0;

  int mShadow;        // value calc would hold, per the model
  int expQ[$];        // expected command sequence, 1=dec 2=inc 3=clear

  calc_cmd_driver dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .comA(comA), .comB(comB), .busy(busy), .done(done), .shadow(shadow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    int expK;
    int firstCmd;
  } vecT;

  vecT vecs[8];

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPassed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Shortest path chosen from the three candidate costs with the stated tie rules.
  function automatic void buildCmds(input int s, input int t);
    int up, down, best;
    expQ.delete();
    if (s == t) return;
    up   = (t - s + 256) % 256;
    down = (s - t + 256) % 256;
    best = (up <= down) ? up : down;
    if (t + 1 < best) begin
      expQ.push_back(3);
      repeat (t) expQ.push_back(2);
    end else if (up <= down) begin
      repeat (up) expQ.push_back(2);
    end else begin
      repeat (down) expQ.push_back(1);
    end
  endfunction

  function automatic int applyCmd(input int s, input int c);
    case (c)
      1: return (s + 255) % 256;
      2: return (s + 1) % 256;
      3: return 0;
      default: return s;
    endcase
  endfunction

  // Called on a negedge in an IDLE cycle; returns on the negedge of the first IDLE cycle after.
  task automatic runTxn(input int t, input int expK, input int firstCmd, input bit inject);
    buildCmds(mShadow, t);
    start  = 1'b1;
    target = t[7:0];
    @(posedge clk);
    #1;
    start  = 1'b0;
    target = 8'($urandom_range(0, 255));
    for (int i = 0; i < expK; i++) begin
      @(negedge clk);
      check($sformatf("cmd t=%0d i=%0d", t, i), {30'd0, comA, comB},
            (i < expQ.size()) ? expQ[i] : 0);
      if (i == 0) check($sformatf("first cmd t=%0d", t), {30'd0, comA, comB}, firstCmd);
      check($sformatf("busy t=%0d i=%0d", t, i), busy, 1);
      check($sformatf("done early t=%0d i=%0d", t, i), done, 0);
      check($sformatf("shadow t=%0d i=%0d", t, i), shadow, mShadow);
      mShadow = applyCmd(mShadow, (i < expQ.size()) ? expQ[i] : 0);
      if (inject && i == 10) begin
        start  = 1'b1;
        target = 8'd7;
      end else if (inject && i == 11) begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check($sformatf("done pulse t=%0d", t), done, 1);
    check($sformatf("done busy t=%0d", t), busy, 1);
    check($sformatf("done cmd t=%0d", t), {30'd0, comA, comB}, 0);
    check($sformatf("done shadow t=%0d", t), shadow, t);
    @(negedge clk);
    check($sformatf("idle done t=%0d", t), done, 0);
    check($sformatf("idle busy t=%0d", t), busy, 0);
    check($sformatf("idle cmd t=%0d", t), {30'd0, comA, comB}, 0);
  endtask

  initial begin
    vecs[0] = '{tgt: 0,   expK: 0,   firstCmd: 0};
    vecs[1] = '{tgt: 5,   expK: 5,   firstCmd: 2};
    vecs[2] = '{tgt: 250, expK: 11,  firstCmd: 1};
    vecs[3] = '{tgt: 200, expK: 50,  firstCmd: 1};
    vecs[4] = '{tgt: 3,   expK: 4,   firstCmd: 3};
    vecs[5] = '{tgt: 100, expK: 97,  firstCmd: 2};
    vecs[6] = '{tgt: 0,   expK: 1,   firstCmd: 3};
    vecs[7] = '{tgt: 128, expK: 128, firstCmd: 2};

    // Reset held with start asserted.
    rst = 1'b1; start = 1'b1; target = 8'd0;
    mShadow = 0;
    repeat (3) @(negedge clk);
    check("reset comA", comA, 0);
    check("reset comB", comB, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset shadow", shadow, 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++)
      runTxn(vecs[v].tgt, vecs[v].expK, vecs[v].firstCmd, v == 7);

    // Asynchronous reset in the middle of a step run.
    begin
      int t;
      t = (mShadow + 60) % 256;
      start = 1'b1; target = t[7:0];
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      check("midrun busy before rst", busy, 1);
      rst = 1'b1;
      #1;
      check("async rst cmd", {30'd0, comA, comB}, 0);
      check("async rst busy", busy, 0);
      check("async rst done", done, 0);
      check("async rst shadow", shadow, 0);
      @(negedge clk);
      rst = 1'b0;
      mShadow = 0;
      @(negedge clk);
      check("post rst idle busy", busy, 0);
      runTxn(2, 2, 2, 1'b0);
    end

    // Random targets; the model supplies both length and contents.
    for (int r = 0; r < 24; r++) begin
      int t;
      t = (r % 6 == 5) ? mShadow : int'($urandom_range(0, 255));
      buildCmds(mShadow, t);
      runTxn(t, expQ.size(), (expQ.size() > 0) ? expQ[0] : 0, 1'b0);
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
